bit8_to_trit5: RTL and testbench

Unpacks one 8-bit packed byte into 5 trits, the inverse of the team's 5-trit-to-byte packer. It is used in NTRU-HRSS ciphertext/key decoding, where byte c = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4. The block is iterative: one divide-by-3 per cycle, with valid/ready handshakes on both sides, so it sits directly between the byte stream and the polynomial coefficient buffer.

---
 rtl/bit8_to_trit5_pkg.sv | 35 +++
 rtl/bit8_to_trit5_if.sv | 36 +++
 rtl/bit8_to_trit5_divmod3.sv | 29 ++
 rtl/bit8_to_trit5.sv | 97 +++++++++
 tb/tb_bit8_to_trit5.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bit8_to_trit5_pkg.sv
// Shared types and constants for the 5-trit packer/unpacker pair.
// SIGNED_TRIT_EN: trit value 2 encodes as 2'b11 instead of 2'b10.
package ntru_pack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
`ifdef SIGNED_TRIT_EN
  localparam logic [1:0] TRIT_TWO  = 2'b11;
`else
  localparam logic [1:0] TRIT_TWO  = 2'b10;
`endif

  localparam logic [7:0] MAX_PACKED = 8'd242;

  // map a remainder 0..2 onto its output trit code
  function automatic logic [1:0] trit_code(
    input logic [1:0] r
  );
    logic [1:0] c;
    c = TRIT_ZERO;
    unique case (1'b1)
      (r == 2'd1): c = TRIT_ONE;
      (r == 2'd2): c = TRIT_TWO;
      default:     c = TRIT_ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bit8_to_trit5_if.sv
// Byte-in / trits-out valid-ready bundle for the trit unpacker.
// master drives bytes and consumes trits; slave is the unpacker.
interface bit8_to_trit5_if #(
  parameter int NUM_TRITS = 5,
  parameter int IN_W      = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W-1:0]        in_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*NUM_TRITS-1:0] out_trits;
  logic                   out_err;

  modport master (
    output in_valid,
    output in_byte,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_trits,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_trits,
    output out_err
  );

endinterface

// File: rtl/bit8_to_trit5_divmod3.sv
// Constant divide-by-3 of an 8-bit value, long division unrolled.
// Remainder never exceeds 2, so a 3-bit trial subtract suffices.
module divmod3_u8 (
  input  logic [7:0] in,
  output logic [7:0] q,
  output logic [1:0] r
);

  logic [1:0] acc;
  logic [2:0] t;

  // shift in one dividend bit at a time, subtract 3 when it fits
  always_comb begin
    q   = '0;
    acc = '0;
    t   = '0;
    for (int i = 7; i >= 0; i--) begin
      t = {acc, in[i]};
      if (t >= 3'd3) begin
        q[i] = 1'b1;
        acc  = 2'(t - 3'd3);
      end else begin
        acc  = t[1:0];
      end
    end
    r = acc;
  end

endmodule

// File: rtl/bit8_to_trit5.sv
// Iterative byte-to-5-trit unpacker, one divide-by-3 per cycle.
// SIGNED_TRIT_EN selects 2'b11 for trit value 2 (see package).
module bit8_to_trit5
  import ntru_pack_pkg::*;
#(
  parameter int NUM_TRITS = 5,
  parameter int IN_W      = 8
) (
  input logic             clk,
  input logic             rst,
  bit8_to_trit5_if.slave  bus
);

  localparam int CW = $clog2(NUM_TRITS);
  localparam int TW = 2 * NUM_TRITS;
  localparam logic [CW-1:0] LAST = CW'(NUM_TRITS - 1);

  state_t          state;
  state_t          state_nx;
  logic [IN_W-1:0] rem;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   trits;
  logic            err;
  logic [7:0]      q;
  logic [1:0]      r;

  divmod3_u8 u_div (
    .in (rem),
    .q  (q),
    .r  (r)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state; outputs decode from state only
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = DIV;
      end
      DIV: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // rejected bytes still run all divide steps; only the output is masked
  always_comb begin
    bus.out_err   = bus.out_valid & err;
    bus.out_trits = '0;
    if (bus.out_valid && !err) bus.out_trits = trits;
  end

  // latch the byte, then peel one trit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      cnt   <= '0;
      trits <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rem   <= bus.in_byte;
            cnt   <= '0;
            trits <= '0;
            err   <= (bus.in_byte > MAX_PACKED);
          end
        end
        DIV: begin
          trits[{cnt, 1'b0} +: 2] <= trit_code(r);
          rem <= q;
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit8_to_trit5.sv
// Self-checking bench for bit8_to_trit5: table vectors, hand sequences,
// and a shuffled sweep over all bytes against an arithmetic model.
module tb_bit8_to_trit5;

`ifdef SIGNED_TRIT_EN
  localparam logic [1:0] T2 = 2'b11;
`else
  localparam logic [1:0] T2 = 2'b10;
`endif

  typedef struct {
    logic [7:0] b;
    logic [9:0] t;
    logic       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   bad = 0;

  bit8_to_trit5_if #(.NUM_TRITS(5), .IN_W(8)) bus ();

  bit8_to_trit5 #(.NUM_TRITS(5), .IN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // base-3 expansion by plain arithmetic
  function automatic logic [10:0] model(input int b);
    logic [9:0] t;
    int v;
    int d;
    t = '0;
    v = b;
    if (b > 242) return {1'b1, 10'h000};
    for (int i = 0; i < 5; i++) begin
      d = v % 3;
      v = v / 3;
      t[2*i +: 2] = (d == 2) ? T2 : 2'(d);
    end
    return {1'b0, t};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // present a byte for one edge, then count cycles to out_valid
  task automatic send(input logic [7:0] b, output int lat);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input logic [7:0] b, input logic [9:0] et,
                           input logic ee, input int stall);
    int lat;
    wait_ready();
    bus.out_ready = (stall == 0);
    send(b, lat);
    chk("latency", 32'(lat), 32'd5);
    chk("trits", 32'(bus.out_trits), 32'(et));
    chk("err", 32'(bus.out_err), 32'(ee));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_trits", 32'({bus.out_err, bus.out_trits}),
          32'({ee, et}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    logic [10:0] m;
    int          order[256];
    int          lat;
    logic        seen;

    tbl[0] = '{8'd0,   10'h000, 1'b0};
`ifdef SIGNED_TRIT_EN
    tbl[1] = '{8'd100, 10'h131, 1'b0};
    tbl[2] = '{8'd242, 10'h3FF, 1'b0};
    tbl[6] = '{8'd2,   10'h003, 1'b0};
`else
    tbl[1] = '{8'd100, 10'h121, 1'b0};
    tbl[2] = '{8'd242, 10'h2AA, 1'b0};
    tbl[6] = '{8'd2,   10'h002, 1'b0};
`endif
    tbl[3] = '{8'd243, 10'h000, 1'b1};
    tbl[4] = '{8'd255, 10'h000, 1'b1};
    tbl[5] = '{8'd3,   10'h004, 1'b0};
    tbl[7] = '{8'd81,  10'h100, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_trits", 32'(bus.out_trits), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);

    for (int i = 0; i < 8; i++)
      run_check(tbl[i].b, tbl[i].t, tbl[i].e, 0);

    // long backpressure in DONE
    run_check(8'd100, tbl[1].t, 1'b0, 10);

    // in_valid ignored in DIV; in_valid with out_ready in DONE not taken
    wait_ready();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_byte   = 8'd100;
    @(negedge clk);
    bus.in_byte = 8'd255;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("div_ign_lat", 32'(lat), 32'd5);
    chk("div_ign_trits", 32'(bus.out_trits), 32'(tbl[1].t));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("no_overlap_ready", 32'(bus.in_ready), 32'd1);
    chk("no_overlap_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("no_overlap_idle", 32'(bus.in_ready), 32'd1);

    // reset during the third divide step
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_byte   = 8'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_trits", 32'(bus.out_trits), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_check(8'd100, tbl[1].t, 1'b0, 0);

    // every byte once in shuffled order with random stalls
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int s;
      j = int'($urandom_range(i, 0));
      s = order[i];
      order[i] = order[j];
      order[j] = s;
    end
    for (int i = 0; i < 256; i++) begin
      m = model(order[i]);
      run_check(8'(order[i]), m[9:0], m[10],
                int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
